// File: rtl/hilo_muldiv_if.sv
// Pipeline-facing signal bundle for the HI/LO multiply/divide unit.
// The pipeline drives the master side; the unit implements the slave side.
interface hilo_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             HiloWrite;
  logic             HilotoReg;
  logic             HiloSrc;
  logic [WIDTH-1:0] MoveData;
  logic             Flush;
  logic             Stall;
  logic             Busy;
  logic [WIDTH-1:0] HiOut;
  logic [WIDTH-1:0] LoOut;

  modport master (
    output Start, Op, SrcA, SrcB, HiloWrite, HilotoReg, HiloSrc, MoveData, Flush,
    input  Stall, Busy, HiOut, LoOut
  );

  modport slave (
    input  Start, Op, SrcA, SrcB, HiloWrite, HilotoReg, HiloSrc, MoveData, Flush,
    output Stall, Busy, HiOut, LoOut
  );
endinterface

// File: rtl/hilo_muldiv.sv
// Iterative radix-2 multiply/divide with HI/LO registers for the EX stage.
// Operations run on magnitudes for 32 cycles; signs are applied on the final step.
module hilo_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          resetn,
  hilo_muldiv_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int unsigned W2 = 2 * WIDTH;

  logic [1:0]       state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic             is_signed;
  logic             move_req;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [W2-1:0]    step;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign accept    = (state_q == S_IDLE) & bus.Start & ~bus.Flush;
  assign is_signed = ~bus.Op[0];
  assign move_req  = bus.HiloWrite & bus.HiloSrc & ~bus.Flush;
  assign abs_a     = (is_signed & bus.SrcA[WIDTH-1]) ? (~bus.SrcA + 1'b1) : bus.SrcA;
  assign abs_b     = (is_signed & bus.SrcB[WIDTH-1]) ? (~bus.SrcB + 1'b1) : bus.SrcB;

  // acc holds {partial product | remainder, multiplier | dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_trial = acc_q[W2-2:WIDTH-1] - {1'b0, opb_q};
    if (is_div_q) begin
      if (!div_trial[WIDTH]) begin
        step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        step = {acc_q[W2-2:0], 1'b0};
      end
    end else begin
      step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Divide by zero yields an all-ones quotient regardless of operand signs.
  always_comb begin
    prod_fix = neg_q ? (~step + 1'b1) : step;
    quo_fix  = dz_q ? '1 : (neg_q ? (~step[WIDTH-1:0] + 1'b1) : step[WIDTH-1:0]);
    rem_fix  = rem_neg_q ? (~step[W2-1:WIDTH] + 1'b1) : step[W2-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    acc_d     = acc_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;

    if ((state_q != S_CALC) && move_req) begin
      if (bus.HilotoReg) begin
        hi_d = bus.MoveData;
      end else begin
        lo_d = bus.MoveData;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_CALC;
          cnt_d     = '0;
          opb_d     = abs_b;
          acc_d     = {{WIDTH{1'b0}}, abs_a};
          is_div_d  = bus.Op[1];
          neg_d     = is_signed & (bus.SrcA[WIDTH-1] ^ bus.SrcB[WIDTH-1]);
          rem_neg_d = is_signed & bus.SrcA[WIDTH-1];
          dz_d      = bus.Op[1] & (bus.SrcB == '0);
        end
      end
      S_CALC: begin
        if (bus.Flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = S_DONE;
            if (is_div_q) begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end else begin
              hi_d = prod_fix[W2-1:WIDTH];
              lo_d = prod_fix[WIDTH-1:0];
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      acc_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opb_q     <= opb_d;
      acc_q     <= acc_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
    end
  end

  assign bus.Stall = accept | ((state_q == S_CALC) & ~bus.Flush);
  assign bus.Busy  = (state_q == S_CALC);
  assign bus.HiOut = hi_q;
  assign bus.LoOut = lo_q;
endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: expected {HI,LO} queued at issue,
// compared by a monitor whenever Busy falls.
module tb_hilo_muldiv;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  hilo_muldiv_if #(.WIDTH(32)) bus ();
  hilo_muldiv #(.WIDTH(32)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        busy_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb;
    int     ia, ib, q, r;
    logic [31:0] qv, rv;
    case (op)
      2'b00: begin
        sa = $signed(a);
        sb = $signed(b);
        return 64'(sa * sb);
      end
      2'b01: return {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        ia = $signed(a);
        ib = $signed(b);
        q  = ia / ib;
        r  = ia % ib;
        qv = q;
        rv = r;
        return {rv, qv};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (busy_prev && !bus.Busy) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got %h%h required no completion", bus.HiOut, bus.LoOut);
      end else begin
        check("sb_hilo", {bus.HiOut, bus.LoOut}, exp_q.pop_front());
      end
    end
    busy_prev = bus.Busy;
  end

  // Called just after a rising edge; returns just after the edge that ends DONE.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] expv);
    int n;
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.SrcA  = a;
    bus.SrcB  = b;
    exp_q.push_back(expv);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.Stall) break;
      n++;
      if (n == 33) check("hilo_before_write", {bus.HiOut, bus.LoOut}, {m_hi, m_lo});
    end
    check("stall_cycles", 64'(n), 64'd33);
    check("done_not_busy", {63'b0, bus.Busy}, 64'd0);
    m_hi = expv[63:32];
    m_lo = expv[31:0];
    @(posedge clk);
    #1;
  endtask

  task automatic release_start();
    bus.Start = 1'b0;
    @(negedge clk);
    check("idle_after_done", {62'b0, bus.Busy, bus.Stall}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_move(input logic to_hi, input logic [31:0] data, input logic src,
                         input logic flush);
    bus.HiloWrite = 1'b1;
    bus.HiloSrc   = src;
    bus.HilotoReg = to_hi;
    bus.MoveData  = data;
    bus.Flush     = flush;
    @(negedge clk);
    check("move_no_stall", {63'b0, bus.Stall}, 64'd0);
    @(posedge clk);
    #1;
    bus.HiloWrite = 1'b0;
    bus.HiloSrc   = 1'b0;
    bus.Flush     = 1'b0;
    if (src && !flush) begin
      if (to_hi) m_hi = data;
      else       m_lo = data;
    end
    @(negedge clk);
    check("move_result", {bus.HiOut, bus.LoOut}, {m_hi, m_lo});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    int unsigned sel;

    bus.Start = 1'b0;  bus.Op = 2'b00;  bus.SrcA = '0;  bus.SrcB = '0;
    bus.HiloWrite = 1'b0;  bus.HilotoReg = 1'b0;  bus.HiloSrc = 1'b0;
    bus.MoveData = '0;  bus.Flush = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {62'b0, bus.Stall, bus.Busy}, 64'd0);
    check("reset_hilo", {bus.HiOut, bus.LoOut}, 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    issue(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA);
    release_start();
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    release_start();
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD);
    release_start();
    issue(2'b11, 32'h0000_0007, 32'h0000_0000, 64'h0000_0007_FFFF_FFFF);
    release_start();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    issue(2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
    release_start();

    do_move(1'b1, 32'h1234_5678, 1'b1, 1'b0);
    do_move(1'b0, 32'hCAFE_F00D, 1'b1, 1'b0);
    do_move(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    do_move(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1);

    do_move(1'b1, 32'd1, 1'b1, 1'b0);
    do_move(1'b0, 32'd2, 1'b1, 1'b0);
    bus.Start = 1'b1;  bus.Op = 2'b00;  bus.SrcA = 32'd123;  bus.SrcB = 32'd456;
    exp_q.push_back({m_hi, m_lo});
    repeat (10) @(posedge clk);
    #1;
    bus.Flush = 1'b1;
    @(negedge clk);
    check("flush_stall_drop", {62'b0, bus.Busy, bus.Stall}, 64'd2);
    @(posedge clk);
    #1;
    bus.Flush = 1'b0;
    bus.Start = 1'b0;
    @(negedge clk);
    check("flush_idle", {63'b0, bus.Busy}, 64'd0);
    @(posedge clk);
    #1;

    bus.Start = 1'b1;  bus.Op = 2'b11;  bus.SrcA = $urandom;  bus.SrcB = $urandom;
    exp_q.push_back(64'd0);
    repeat (6) @(posedge clk);
    #1;
    resetn = 1'b0;
    bus.Start = 1'b0;
    @(negedge clk);
    check("rst_mid_calc_busy", {63'b0, bus.Busy}, 64'd0);
    check("rst_mid_calc_hilo", {bus.HiOut, bus.LoOut}, 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    m_hi = '0;
    m_lo = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      op  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      a   = $urandom;
      b   = $urandom;
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 200)); b = 32'($urandom_range(1, 20)); end
        3: b = -32'($urandom_range(1, 20));
        default: ;
      endcase
      issue(op, a, b, ref_model(op, a, b));
      release_start();
      if ($urandom_range(0, 2) == 0) do_move(1'($urandom_range(0, 1)), $urandom, 1'b1, 1'b0);
    end

    repeat (3) @(posedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

- Iterative multiply/divide unit and HI/LO register file for the EX stage.
- Consumes the control that the main decoder produces for MULT/MULTU/DIV/DIVU and MTHI/MTLO.
- Holds the pipeline through `Stall` while a 32-step operation runs, then writes HI/LO.
- Drives `HiOut`/`LoOut` for MFHI/MFLO.

## Interface
- `WIDTH`, default 32: operand width. Only 32 is supported; the counter is 5 bits.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `Start` in 1: EX-stage mul/div instruction valid. Held high while `Stall` is high.
- `Op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled only on accept.
- `SrcA`, `SrcB` in 32: rs and rt operands. Sampled only on accept.
- `HiloWrite` in 1: HI/LO write request from the decoder.
- `HilotoReg` in 1: move target, 1 = HI, 0 = LO.
- `HiloSrc` in 1: 1 = move instruction (MTHI/MTLO); 0 = ALU-sourced, ignored here.
- `MoveData` in 32: rs value for MTHI/MTLO.
- `Flush` in 1: cancels the EX-stage instruction.
- `Stall` out 1: freeze IF/ID/EX.
- `Busy` out 1: state is CALC.
- `HiOut`, `LoOut` out 32: current HI and LO registers.

## Operation
State machine: IDLE, CALC, DONE.

- **IDLE**
  - Accept when `Start & ~Flush`.
  - On accept, latch the operand magnitudes. Signed ops (Op[0]=0) use two's-complement absolute values. Record the result signs:
    - product sign and quotient sign = SrcA[31]^SrcB[31];
    - remainder sign = SrcA[31].
    - Unsigned ops force both signs to 0.
  - Clear the 5-bit counter. Go to CALC.
- **CALC**: one radix-2 step per cycle, 32 cycles (counter 0..31).
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring division, one quotient bit per cycle.
  - When counter = 31:
    - apply sign correction (negate as recorded);
    - write HI = upper product / remainder and LO = lower product / quotient;
    - go to DONE.
  - If `Flush`=1 in any CALC cycle: go to IDLE, leave HI/LO untouched, drop `Stall` that cycle.
- **DONE**: `Start` is ignored, because it is the same instruction being released. Go to IDLE unconditionally.

Move path:
- When `HiloWrite & HiloSrc & ~Flush` and state is not CALC, write `MoveData` into HI if `HilotoReg`=1, else into LO.
- `HiloWrite` with `HiloSrc`=0 (the mul/div encoding) has no effect; the FSM alone writes the results.

Arithmetic rules:
- Divide by zero: quotient = 0xFFFFFFFF, remainder = SrcA, for both signedness modes. Still takes 32 cycles.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This is the natural wrap; no trap.
- All sums are taken mod 2^32 per half.

Outputs:
- `Stall` = (IDLE & `Start` & ~`Flush`) | (CALC & ~`Flush`).
- `Busy` = CALC.

## Timing
- Reset (async assert, synchronous release on the next edge):
  - state IDLE, counter 0;
  - HI = LO = 0;
  - `Stall` = 0, `Busy` = 0.
- Accept cycle is cycle 0; `Stall` is high combinationally in it.
- CALC occupies cycles 1..32 with `Stall` high. Total stall is 33 cycles.
- HI/LO are written on the edge ending cycle 32. They are visible on `HiOut`/`LoOut` in cycle 33 (DONE), where `Stall` = 0.
- An MFHI in the instruction directly after the mul/div reads the new value; no forwarding is needed.
- A back-to-back mul/div is accepted at the earliest in cycle 34 (IDLE), i.e. it stalls again immediately.
- A move in the same cycle as a CALC completion cannot occur (pipeline frozen). If it is forced in a bench, the CALC result wins.
- `resetn` asserted mid-CALC: immediate IDLE, HI = LO = 0.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 → `Stall` high for 33 cycles; in DONE, HI = 0xFFFFFFFF and LO = 0xFFFFFFFA.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001, written exactly at cycle 33.
- DIV −7 (0xFFFFFFF9) / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 7 / 0 → LO = 0xFFFFFFFF, HI = 0x00000007.
- DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0. Then back-to-back DIVU 100 / 7 → second accept in cycle 34, LO = 14, HI = 2.
- MTHI 0x12345678, then MTLO 0xCAFEF00D → HiOut/LoOut update on the following edges. `Stall` stays 0 throughout.
- Preload HI=1, LO=2. Start MULT, then assert `Flush` at CALC cycle 10 → `Stall` drops that cycle and state returns to IDLE with HI=1, LO=2. Separately, `resetn`=0 mid-CALC → HI = LO = 0, `Busy` = 0.
